// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bundle between the ID-stage decoder/datapath and ctrl_pipe.
// The master drives the decoded ID fields and the EX branch result; ctrl_pipe is the slave.
interface ctrl_pipe_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_ALUSrc;
  logic             id_MemToReg;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic             id_MemWrite;
  logic [1:0]       id_ALUOp;
  logic             id_Branch;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             ex_branch_taken;

  logic             ex_ALUSrc;
  logic             ex_MemToReg;
  logic             ex_RegWrite;
  logic             ex_MemRead;
  logic             ex_MemWrite;
  logic             ex_Branch;
  logic [1:0]       ex_ALUOp;
  logic [REG_W-1:0] ex_rs1;
  logic [REG_W-1:0] ex_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             mem_RegWrite;
  logic             mem_MemToReg;
  logic             mem_MemRead;
  logic             mem_MemWrite;
  logic [REG_W-1:0] mem_rd;
  logic             wb_RegWrite;
  logic             wb_MemToReg;
  logic [REG_W-1:0] wb_rd;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_ALUSrc, id_MemToReg, id_RegWrite, id_MemRead, id_MemWrite,
           id_ALUOp, id_Branch, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  ex_ALUSrc, ex_MemToReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
           ex_Branch, ex_ALUOp, ex_rs1, ex_rs2, ex_rd,
           mem_RegWrite, mem_MemToReg, mem_MemRead, mem_MemWrite, mem_rd,
           wb_RegWrite, wb_MemToReg, wb_rd,
           pc_write, ifid_write, ifid_flush, forward_a, forward_b,
           stall_count, flush_count
  );

  modport slave (
    input  id_ALUSrc, id_MemToReg, id_RegWrite, id_MemRead, id_MemWrite,
           id_ALUOp, id_Branch, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output ex_ALUSrc, ex_MemToReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
           ex_Branch, ex_ALUOp, ex_rs1, ex_rs2, ex_rd,
           mem_RegWrite, mem_MemToReg, mem_MemRead, mem_MemWrite, mem_rd,
           wb_RegWrite, wb_MemToReg, wb_rd,
           pc_write, ifid_write, ifid_flush, forward_a, forward_b,
           stall_count, flush_count
  );
endinterface

// File: rtl/ctrl_pipe.sv
// RV32I 5-stage pipeline control: carries decoder control ID->EX->MEM->WB, handles
// load-use stalls and taken-branch flushes, selects EX forwarding, counts stalls/flushes.
module ctrl_pipe #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input logic        clk,
  input logic        reset,
  ctrl_pipe_if.slave bus
);
  localparam logic [REG_W-1:0] X0      = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hz;
  logic br;
  logic bubble;

  assign hz = bus.ex_MemRead && (bus.ex_rd != X0) &&
              ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  // A taken branch squashes the instruction in ID, so any hazard it raised is moot.
  assign br     = bus.ex_Branch && bus.ex_branch_taken;
  assign bubble = br || hz;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.ifid_flush = 1'b0;
    if (br) begin
      bus.ifid_flush = 1'b1;
    end else if (hz) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
    end
  end

  // EX/MEM result wins over MEM/WB because it is the younger write; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             mem_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_rd
  );
    if (mem_we && (mem_rd != X0) && (mem_rd == rs)) return 2'b10;
    if (wb_we && (wb_rd != X0) && (wb_rd == rs))    return 2'b01;
    return 2'b00;
  endfunction

  assign bus.forward_a = fwd_sel(bus.ex_rs1, bus.mem_RegWrite, bus.mem_rd,
                                 bus.wb_RegWrite, bus.wb_rd);
  assign bus.forward_b = fwd_sel(bus.ex_rs2, bus.mem_RegWrite, bus.mem_rd,
                                 bus.wb_RegWrite, bus.wb_rd);

  // ID/EX: a bubble clears the whole register, operand fields included.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    if (!reset || bubble) begin
      bus.ex_ALUSrc   <= 1'b0;
      bus.ex_MemToReg <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_MemRead  <= 1'b0;
      bus.ex_MemWrite <= 1'b0;
      bus.ex_Branch   <= 1'b0;
      bus.ex_ALUOp    <= 2'b00;
      bus.ex_rs1      <= X0;
      bus.ex_rs2      <= X0;
      bus.ex_rd       <= X0;
    end else begin
      bus.ex_ALUSrc   <= bus.id_ALUSrc;
      bus.ex_MemToReg <= bus.id_MemToReg;
      bus.ex_RegWrite <= bus.id_RegWrite;
      bus.ex_MemRead  <= bus.id_MemRead;
      bus.ex_MemWrite <= bus.id_MemWrite;
      bus.ex_Branch   <= bus.id_Branch;
      bus.ex_ALUOp    <= bus.id_ALUOp;
      bus.ex_rs1      <= bus.id_rs1;
      bus.ex_rs2      <= bus.id_rs2;
      bus.ex_rd       <= bus.id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_RegWrite <= 1'b0;
      bus.mem_MemToReg <= 1'b0;
      bus.mem_MemRead  <= 1'b0;
      bus.mem_MemWrite <= 1'b0;
      bus.mem_rd       <= X0;
      bus.wb_RegWrite  <= 1'b0;
      bus.wb_MemToReg  <= 1'b0;
      bus.wb_rd        <= X0;
    end else begin
      bus.mem_RegWrite <= bus.ex_RegWrite;
      bus.mem_MemToReg <= bus.ex_MemToReg;
      bus.mem_MemRead  <= bus.ex_MemRead;
      bus.mem_MemWrite <= bus.ex_MemWrite;
      bus.mem_rd       <= bus.ex_rd;
      bus.wb_RegWrite  <= bus.mem_RegWrite;
      bus.wb_MemToReg  <= bus.mem_MemToReg;
      bus.wb_rd        <= bus.mem_rd;
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.stall_count <= '0;
      bus.flush_count <= '0;
    end else begin
      if (hz && !br && (bus.stall_count != CNT_MAX))
        bus.stall_count <= bus.stall_count + CNT_W'(1);
      if (br && (bus.flush_count != CNT_MAX))
        bus.flush_count <= bus.flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios plus random traffic against an instruction-level
// model; a second copy with 2-bit counters shares the stimulus to observe saturation.
module tb_ctrl_pipe;
  typedef struct packed {
    logic       alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0] aluop;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  instr_t cur = '0;
  logic   taken = 1'b0;
  int     n_tests = 0;
  int     n_fail = 0;

  instr_t m_ex, m_mem, m_wb;
  int     m_stall, m_flush;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.REG_W(5), .CNT_W(16)) bus ();
  ctrl_pipe_if #(.REG_W(5), .CNT_W(2))  bus_s ();

  ctrl_pipe #(.CNT_W(16), .REG_W(5)) dut   (.clk(clk), .reset(reset), .bus(bus));
  ctrl_pipe #(.CNT_W(2),  .REG_W(5)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  assign bus.id_ALUSrc = cur.alusrc;     assign bus_s.id_ALUSrc = cur.alusrc;
  assign bus.id_MemToReg = cur.memtoreg; assign bus_s.id_MemToReg = cur.memtoreg;
  assign bus.id_RegWrite = cur.regwrite; assign bus_s.id_RegWrite = cur.regwrite;
  assign bus.id_MemRead = cur.memread;   assign bus_s.id_MemRead = cur.memread;
  assign bus.id_MemWrite = cur.memwrite; assign bus_s.id_MemWrite = cur.memwrite;
  assign bus.id_ALUOp = cur.aluop;       assign bus_s.id_ALUOp = cur.aluop;
  assign bus.id_Branch = cur.branch;     assign bus_s.id_Branch = cur.branch;
  assign bus.id_rs1 = cur.rs1;           assign bus_s.id_rs1 = cur.rs1;
  assign bus.id_rs2 = cur.rs2;           assign bus_s.id_rs2 = cur.rs2;
  assign bus.id_rd = cur.rd;             assign bus_s.id_rd = cur.rd;
  assign bus.ex_branch_taken = taken;    assign bus_s.ex_branch_taken = taken;

  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i = '0;
    i.alusrc = 1; i.memtoreg = 1; i.regwrite = 1; i.memread = 1;
    i.aluop = 2'b00; i.rs1 = rs1; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.regwrite = 1; i.aluop = 2'b10; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t beq(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.branch = 1; i.aluop = 2'b01; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  // Model rules, stated over whole instructions sitting in each stage.
  function automatic logic m_hz();
    return m_ex.memread && m_ex.rd != 0 && (m_ex.rd == cur.rs1 || m_ex.rd == cur.rs2);
  endfunction

  function automatic logic m_br();
    return m_ex.branch && taken;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (m_mem.regwrite && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
    if (m_wb.regwrite && m_wb.rd != 0 && m_wb.rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic instr_t ex_vec();
    return {bus.ex_ALUSrc, bus.ex_MemToReg, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite,
            bus.ex_Branch, bus.ex_ALUOp, bus.ex_rs1, bus.ex_rs2, bus.ex_rd};
  endfunction

  // One clock: the instruction in ID enters EX unless a flush or load-use bubble replaces it.
  task automatic tick();
    logic h, b;
    h = m_hz();
    b = m_br();
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = (h || b) ? instr_t'('0) : cur;
    if (b) m_flush++;
    else if (h) m_stall++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cur = '0;
    taken = 1'b0;
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_stall = 0; m_flush = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ex_vec() !== 23'd0) begin n_fail++; $display("FAIL reset_ex got=%h exp=0", ex_vec()); end
    n_tests++; if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1 || bus.ifid_flush !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl got=%b%b%b exp=110", bus.pc_write, bus.ifid_write, bus.ifid_flush); end
    // Load the pipe and count a stall, then drop reset between edges.
    cur = lw(5, 1); tick();
    cur = alu(6, 5, 7); tick(); tick();
    n_tests++; if (bus.stall_count !== 16'd1) begin n_fail++; $display("FAIL preload_stall got=%0d exp=1", bus.stall_count); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (ex_vec() !== 23'd0) begin n_fail++; $display("FAIL async_ex got=%h exp=0", ex_vec()); end
    n_tests++; if ({bus.mem_RegWrite, bus.mem_MemToReg, bus.mem_MemRead, bus.mem_MemWrite, bus.mem_rd} !== 9'd0 ||
                   {bus.wb_RegWrite, bus.wb_MemToReg, bus.wb_rd} !== 7'd0) begin
      n_fail++; $display("FAIL async_memwb got mem_rd=%0d wb_rd=%0d exp=0", bus.mem_rd, bus.wb_rd); end
    n_tests++; if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin
      n_fail++; $display("FAIL async_cnt got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count); end
    n_tests++; if (bus.pc_write !== 1'b1 || bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin
      n_fail++; $display("FAIL async_comb got pc=%b fa=%b fb=%b exp pc=1 fa=00 fb=00", bus.pc_write, bus.forward_a, bus.forward_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    cur = lw(5, 1); tick();
    cur = alu(6, 5, 7); #1;
    n_tests++; if (bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0 || bus.ifid_flush !== 1'b0) begin
      n_fail++; $display("FAIL lu_stall got=%b%b%b exp=000", bus.pc_write, bus.ifid_write, bus.ifid_flush); end
    tick();
    n_tests++; if (ex_vec() !== 23'd0) begin n_fail++; $display("FAIL lu_bubble got=%h exp=0", ex_vec()); end
    n_tests++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_release got=%b exp=1", bus.pc_write); end
    tick();
    n_tests++; if (bus.ex_rd !== 5'd6 || bus.ex_RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL lu_add_ex got rd=%0d we=%b exp rd=6 we=1", bus.ex_rd, bus.ex_RegWrite); end
    n_tests++; if (bus.forward_a !== 2'b01 || bus.forward_b !== 2'b00) begin
      n_fail++; $display("FAIL lu_fwd got=%b/%b exp=01/00", bus.forward_a, bus.forward_b); end
    n_tests++; if (bus.stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count got=%0d exp=1", bus.stall_count); end
  endtask

  task automatic test_forward();
    do_reset();
    cur = alu(3, 1, 2); tick();
    cur = alu(4, 3, 3); tick();
    n_tests++; if (bus.forward_a !== 2'b10 || bus.forward_b !== 2'b10) begin
      n_fail++; $display("FAIL fwd_exmem got=%b/%b exp=10/10", bus.forward_a, bus.forward_b); end
    cur = alu(0, 1, 2); tick();
    cur = alu(8, 0, 0); tick();
    n_tests++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_x0 got=%b/%b exp=00/00", bus.forward_a, bus.forward_b); end
    cur = alu(9, 1, 1); tick();
    cur = alu(9, 2, 2); tick();
    cur = alu(10, 9, 1); tick();
    n_tests++; if (bus.forward_a !== 2'b10 || bus.forward_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_priority got=%b/%b exp=10/00", bus.forward_a, bus.forward_b); end
    cur = alu(11, 1, 1); tick();
    cur = '0; tick();
    cur = alu(12, 2, 11); tick();
    n_tests++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b01) begin
      n_fail++; $display("FAIL fwd_memwb got=%b/%b exp=00/01", bus.forward_a, bus.forward_b); end
  endtask

  task automatic test_branch();
    do_reset();
    cur = beq(1, 2); tick();
    cur = alu(5, 6, 7); taken = 1'b1; #1;
    n_tests++; if (bus.ifid_flush !== 1'b1 || bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin
      n_fail++; $display("FAIL br_flush got=%b%b%b exp=111", bus.ifid_flush, bus.pc_write, bus.ifid_write); end
    tick();
    n_tests++; if (ex_vec() !== 23'd0 || bus.flush_count !== 16'd1) begin
      n_fail++; $display("FAIL br_bubble got ex=%h cnt=%0d exp ex=0 cnt=1", ex_vec(), bus.flush_count); end
    taken = 1'b0; #1;
    n_tests++; if (bus.ifid_flush !== 1'b0) begin n_fail++; $display("FAIL br_one_cycle got=%b exp=0", bus.ifid_flush); end
    cur = beq(1, 2); tick();
    cur = alu(5, 6, 7); #1;
    n_tests++; if (bus.ifid_flush !== 1'b0) begin n_fail++; $display("FAIL br_not_taken got=%b exp=0", bus.ifid_flush); end
    tick();
    n_tests++; if (bus.ex_rd !== 5'd5 || bus.flush_count !== 16'd1) begin
      n_fail++; $display("FAIL br_nt_pass got rd=%0d cnt=%0d exp rd=5 cnt=1", bus.ex_rd, bus.flush_count); end
  endtask

  task automatic test_flush_priority();
    instr_t i;
    do_reset();
    i = lw(5, 1);
    i.branch = 1'b1;
    cur = i; tick();
    cur = alu(6, 5, 5); taken = 1'b1; #1;
    n_tests++; if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1 || bus.ifid_flush !== 1'b1) begin
      n_fail++; $display("FAIL prio_ctl got=%b%b%b exp=111", bus.pc_write, bus.ifid_write, bus.ifid_flush); end
    tick();
    n_tests++; if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd1) begin
      n_fail++; $display("FAIL prio_cnt got=%0d/%0d exp=0/1", bus.stall_count, bus.flush_count); end
    taken = 1'b0;
  endtask

  task automatic test_saturation();
    int exp_sat[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cur = lw(5, 1); tick();
      cur = alu(6, 5, 7); tick();
      n_tests++; if (int'(bus_s.stall_count) !== exp_sat[k]) begin
        n_fail++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", k, bus_s.stall_count, exp_sat[k]); end
      n_tests++; if (int'(bus.stall_count) !== k + 1) begin
        n_fail++; $display("FAIL wide_stall[%0d] got=%0d exp=%0d", k, bus.stall_count, k + 1); end
    end
  endtask

  task automatic test_random();
    instr_t e_mem, e_wb, g_mem, g_wb;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cur = instr_t'($urandom);
      cur.rs1 = 5'($urandom_range(0, 3));
      cur.rs2 = 5'($urandom_range(0, 3));
      cur.rd  = 5'($urandom_range(0, 3));
      taken = 1'($urandom);
      #1;
      n_tests++; if ({bus.pc_write, bus.ifid_write, bus.ifid_flush} !==
                     {m_br() || !m_hz(), m_br() || !m_hz(), m_br()}) begin
        n_fail++; $display("FAIL rnd_ctl[%0d] got=%b%b%b hz=%b br=%b", n, bus.pc_write, bus.ifid_write, bus.ifid_flush, m_hz(), m_br()); end
      n_tests++; if ({bus.forward_a, bus.forward_b} !== {m_fwd(m_ex.rs1), m_fwd(m_ex.rs2)}) begin
        n_fail++; $display("FAIL rnd_fwd[%0d] got=%b/%b exp=%b/%b", n, bus.forward_a, bus.forward_b, m_fwd(m_ex.rs1), m_fwd(m_ex.rs2)); end
      tick();
      n_tests++; if (ex_vec() !== m_ex) begin
        n_fail++; $display("FAIL rnd_ex[%0d] got=%h exp=%h", n, ex_vec(), m_ex); end
      e_mem = '0; e_mem.regwrite = m_mem.regwrite; e_mem.memtoreg = m_mem.memtoreg;
      e_mem.memread = m_mem.memread; e_mem.memwrite = m_mem.memwrite; e_mem.rd = m_mem.rd;
      g_mem = '0; g_mem.regwrite = bus.mem_RegWrite; g_mem.memtoreg = bus.mem_MemToReg;
      g_mem.memread = bus.mem_MemRead; g_mem.memwrite = bus.mem_MemWrite; g_mem.rd = bus.mem_rd;
      e_wb = '0; e_wb.regwrite = m_wb.regwrite; e_wb.memtoreg = m_wb.memtoreg; e_wb.rd = m_wb.rd;
      g_wb = '0; g_wb.regwrite = bus.wb_RegWrite; g_wb.memtoreg = bus.wb_MemToReg; g_wb.rd = bus.wb_rd;
      n_tests++; if (g_mem !== e_mem || g_wb !== e_wb) begin
        n_fail++; $display("FAIL rnd_memwb[%0d] got=%h/%h exp=%h/%h", n, g_mem, g_wb, e_mem, e_wb); end
      n_tests++; if (int'(bus.stall_count) !== m_stall || int'(bus.flush_count) !== m_flush) begin
        n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n, bus.stall_count, bus.flush_count, m_stall, m_flush); end
      n_tests++; if (int'(bus_s.stall_count) !== sat3(m_stall) || int'(bus_s.flush_count) !== sat3(m_flush)) begin
        n_fail++; $display("FAIL rnd_sat[%0d] got=%0d/%0d exp=%0d/%0d", n, bus_s.stall_count, bus_s.flush_count, sat3(m_stall), sat3(m_flush)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_flush_priority();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
